// File: rtl/rf_access_ctrl_if.sv
// rf_access_ctrl_if: request/response bundle between the execute/write-back
// logic (master) and the register-file sequencer (slave).
//   wr_*  : write-back request (valid/ready), register index and value
//   rd_*  : dual-read request (valid/ready), two register indices
//   rsp_* : one-cycle read response pulse with both read results
interface rf_access_ctrl_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data1;
    logic [DW-1:0] rsp_data2;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr1, rd_addr2,
        input  wr_ready, rd_ready, rsp_valid, rsp_data1, rsp_data2
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr1, rd_addr2,
        output wr_ready, rd_ready, rsp_valid, rsp_data1, rsp_data2
    );
endinterface

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: front-end sequencer for a register file that performs either
// one dual read (rf_rw_en=1) or one write (rf_rw_en=0) every cycle.
// Write-back requests are queued in a small FIFO and drained into the RF on
// cycles not used by reads; reads are answered one cycle after acceptance,
// forwarding from writes still sitting in the FIFO.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : rf_access_ctrl_if.slave (write req, read req, read response)
//   rf_rw_en     : RF ReadWriteEn, 1=read, 0=write
//   rf_rd_addr1/2: RF read addresses
//   rf_wr_addr/data: RF write port, always the FIFO head (0 when empty)
//   rf_rd_data1/2: RF read data, registered inside the RF
//   pending      : FIFO occupancy
//
// Optional feature: define RF_ACCESS_ZERO_REG_EN to hardwire register 0 to
// zero (writes to 0 are accepted and dropped, reads of 0 return 0).
module rf_access_ctrl #(
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rf_access_ctrl_if.slave          bus,
    output logic                     rf_rw_en,
    output logic [AW-1:0]            rf_rd_addr1,
    output logic [AW-1:0]            rf_rd_addr2,
    output logic [AW-1:0]            rf_wr_addr,
    output logic [DW-1:0]            rf_wr_data,
    input  logic [DW-1:0]            rf_rd_data1,
    input  logic [DW-1:0]            rf_rd_data2,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {ArbIdle, ArbRead, ArbDrain} arb_e;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;

    logic          full, empty;
    arb_e          arb;
    logic          push, pop, rd_accept;

    logic          hit1, hit2;
    logic [DW-1:0] fwd1, fwd2;

    logic          rsp_valid_q;
    logic          hit1_q, hit2_q;
    logic [DW-1:0] fwd1_q, fwd2_q;
    logic [DW-1:0] hold1_q, hold2_q;
    logic [DW-1:0] rsp1, rsp2;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Arbitration on registered occupancy: a full FIFO must drain before any
    // read, otherwise reads have priority over draining.
    always_comb begin
        arb = ArbIdle;
        if (full) begin
            arb = ArbDrain;
        end else if (bus.rd_valid) begin
            arb = ArbRead;
        end else if (!empty) begin
            arb = ArbDrain;
        end
    end

    assign pop       = (arb == ArbDrain);
    assign rd_accept = (arb == ArbRead);

    assign bus.wr_ready = !full;
    assign bus.rd_ready = !full;

`ifdef RF_ACCESS_ZERO_REG_EN
    // Writes to register 0 are acknowledged but dropped.
    assign push = bus.wr_valid && !full && (bus.wr_addr != '0);
`else
    assign push = bus.wr_valid && !full;
`endif

    // RF side: only a drain cycle may ever write.
    assign rf_rw_en    = (arb != ArbDrain);
    assign rf_rd_addr1 = bus.rd_addr1;
    assign rf_rd_addr2 = bus.rd_addr2;
    assign rf_wr_addr  = empty ? '0 : mem_q[head_q].addr;
    assign rf_wr_data  = empty ? '0 : mem_q[head_q].data;
    assign pending     = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Forwarding: walk entries oldest to newest so the newest match wins.
    // Writes arriving this cycle are not yet in mem_q, so they are ordered
    // after a read accepted in the same cycle.
    always_comb begin : p_fwd
        logic [PW-1:0] idx;
        idx  = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head_q + PW'(k);
            if (k < int'(count_q)) begin
                if (mem_q[idx].addr == bus.rd_addr1) begin
                    hit1 = 1'b1;
                    fwd1 = mem_q[idx].data;
                end
                if (mem_q[idx].addr == bus.rd_addr2) begin
                    hit2 = 1'b1;
                    fwd2 = mem_q[idx].data;
                end
            end
        end
`ifdef RF_ACCESS_ZERO_REG_EN
        if (bus.rd_addr1 == '0) begin
            hit1 = 1'b1;
            fwd1 = '0;
        end
        if (bus.rd_addr2 == '0) begin
            hit2 = 1'b1;
            fwd2 = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage is qualified by count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{addr: bus.wr_addr, data: bus.wr_data};
        end
    end

    // Forwarded data is captured at accept; misses take the RF output, which
    // appears one cycle after the address was presented.
    assign rsp1 = rsp_valid_q ? (hit1_q ? fwd1_q : rf_rd_data1) : hold1_q;
    assign rsp2 = rsp_valid_q ? (hit2_q ? fwd2_q : rf_rd_data2) : hold2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            fwd1_q      <= '0;
            fwd2_q      <= '0;
            hold1_q     <= '0;
            hold2_q     <= '0;
        end else begin
            rsp_valid_q <= rd_accept;
            if (rd_accept) begin
                hit1_q <= hit1;
                hit2_q <= hit2;
                fwd1_q <= fwd1;
                fwd2_q <= fwd2;
            end
            if (rsp_valid_q) begin
                hold1_q <= rsp1;
                hold2_q <= rsp2;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data1 = rsp1;
    assign bus.rsp_data2 = rsp2;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Testbench for rf_access_ctrl: register-file model, architectural reference
// (register values in request order) feeding a response scoreboard, and
// scenario tasks with inline checks.
module tb_rf_access_ctrl;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } rsp_t;

    logic          clk;
    logic          rst_n;
    logic          rf_rw_en;
    logic [AW-1:0] rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic [DW-1:0] rf_rd_data1, rf_rd_data2;
    logic [2:0]    pending;

    int errors = 0;
    int checks = 0;

    rf_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    rf_access_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rf_rw_en    (rf_rw_en),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .pending     (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: one dual read or one write per cycle, registered read data.
    logic [DW-1:0] rf_mem [32];
    logic          rf_loaded = 1'b0;
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h1000 + i;
            rf_loaded <= 1'b1;
        end else if (!rf_rw_en) begin
            rf_mem[rf_wr_addr] <= rf_wr_data;
        end else begin
            rf_rd_data1 <= rf_mem[rf_rd_addr1];
            rf_rd_data2 <= rf_mem[rf_rd_addr2];
        end
    end

    // Architectural register state in request order.
    logic [DW-1:0] arch [32];
    rsp_t          scb [$];
    logic          exp_rsp = 1'b0;

    function automatic logic [DW-1:0] exp_val(input logic [AW-1:0] a);
`ifdef RF_ACCESS_ZERO_REG_EN
        if (a == '0) return '0;
`endif
        return arch[a];
    endfunction

    // Monitor: response latency/data against the scoreboard, and the rule that
    // a write cycle always pops a queued entry.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            checks++;
            if (bus.rsp_valid !== 1'b0)
                $display("FAIL rsp_valid_in_reset: got %0b want 0", bus.rsp_valid);
            if (bus.rsp_valid !== 1'b0) errors++;
            scb.delete();
            exp_rsp = 1'b0;
            for (int i = 0; i < 32; i++) arch[i] = rf_mem[i];
        end else begin
            checks++;
            if (bus.rsp_valid !== exp_rsp) begin
                errors++;
                $display("FAIL rsp_latency t=%0t: rsp_valid=%0b want %0b",
                         $time, bus.rsp_valid, exp_rsp);
            end
            if (bus.rsp_valid === 1'b1 && scb.size() > 0) begin
                e = scb.pop_front();
                checks++;
                if (bus.rsp_data1 !== e.d1 || bus.rsp_data2 !== e.d2) begin
                    errors++;
                    $display("FAIL rsp_data t=%0t: got %h/%h want %h/%h", $time,
                             bus.rsp_data1, bus.rsp_data2, e.d1, e.d2);
                end
            end
            checks++;
            if (rf_rw_en === 1'b0 && pending === 3'd0) begin
                errors++;
                $display("FAIL write_without_pop t=%0t: rf_rw_en=0 pending=0", $time);
            end
            exp_rsp = 1'b0;
            if (bus.rd_valid && bus.rd_ready) begin
                scb.push_back('{d1: exp_val(bus.rd_addr1), d2: exp_val(bus.rd_addr2)});
                exp_rsp = 1'b1;
            end
            if (bus.wr_valid && bus.wr_ready) begin
`ifdef RF_ACCESS_ZERO_REG_EN
                if (bus.wr_addr != '0) arch[bus.wr_addr] = bus.wr_data;
`else
                arch[bus.wr_addr] = bus.wr_data;
`endif
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_valid = 1'b0;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
    endtask

    task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
    endtask

    task automatic drive_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus.rd_valid = 1'b1;
        bus.rd_addr1 = a1;
        bus.rd_addr2 = a2;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pending === 3'd0) break;
        end
        checks++;
        if (pending !== 3'd0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d want 0", pending);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (pending !== 3'd0 || bus.rsp_data1 !== '0 || bus.rsp_data2 !== '0 ||
            rf_rw_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: pending=%0d d1=%h d2=%h rw=%0b want 0/0/0/1",
                     pending, bus.rsp_data1, bus.rsp_data2, rf_rw_en);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.wr_ready !== 1'b1 || rf_rw_en !== 1'b1 || rf_wr_addr !== '0) begin
            errors++;
            $display("FAIL post_reset: wr_ready=%0b rw=%0b wa=%0d want 1/1/0",
                     bus.wr_ready, rf_rw_en, rf_wr_addr);
        end
        next_cycle();
    endtask

    task automatic test_drain();
        drive_wr(5'd5, 32'd12);
        next_cycle();
        drive_wr(5'd15, 32'd33);
        @(negedge clk);
        checks++;
        if (rf_rw_en !== 1'b0 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'd12 ||
            pending !== 3'd1) begin
            errors++;
            $display("FAIL drain_first: rw=%0b wa=%0d wd=%0d pend=%0d want 0/5/12/1",
                     rf_rw_en, rf_wr_addr, rf_wr_data, pending);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rf_rw_en !== 1'b0 || rf_wr_addr !== 5'd15 || rf_wr_data !== 32'd33 ||
            pending !== 3'd1) begin
            errors++;
            $display("FAIL drain_second: rw=%0b wa=%0d wd=%0d pend=%0d want 0/15/33/1",
                     rf_rw_en, rf_wr_addr, rf_wr_data, pending);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rf_rw_en !== 1'b1 || pending !== 3'd0) begin
            errors++;
            $display("FAIL drain_done: rw=%0b pend=%0d want 1/0", rf_rw_en, pending);
        end
        next_cycle();
    endtask

    task automatic test_read();
        drive_rd(5'd5, 5'd15);
        @(negedge clk);
        checks++;
        if (bus.rd_ready !== 1'b1 || rf_rw_en !== 1'b1 || rf_rd_addr1 !== 5'd5) begin
            errors++;
            $display("FAIL read_accept: rd_ready=%0b rw=%0b ra1=%0d want 1/1/5",
                     bus.rd_ready, rf_rw_en, rf_rd_addr1);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data1 !== 32'd12 || bus.rsp_data2 !== 32'd33) begin
            errors++;
            $display("FAIL read_rf: v=%0b d1=%0d d2=%0d want 1/12/33",
                     bus.rsp_valid, bus.rsp_data1, bus.rsp_data2);
        end
        next_cycle();
    endtask

    task automatic test_forward();
        drive_rd(5'd7, 5'd3);
        drive_wr(5'd7, 32'd99);
        next_cycle();
        drive_wr(5'd7, 32'd100);
        next_cycle();
        bus.wr_valid = 1'b0;
        next_cycle();
        bus.rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data1 !== 32'd100 ||
            bus.rsp_data2 !== 32'h1003) begin
            errors++;
            $display("FAIL forward_newest: v=%0b d1=%0d d2=%h want 1/100/1003",
                     bus.rsp_valid, bus.rsp_data1, bus.rsp_data2);
        end
        wait_drain();
    endtask

    task automatic test_full();
        drive_rd(5'd10, 5'd13);
        for (int i = 0; i < 4; i++) begin
            drive_wr(5'(10 + i), 32'(200 + i));
            next_cycle();
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pending !== 3'd4 || bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0 ||
            rf_rw_en !== 1'b0 || rf_wr_addr !== 5'd10 || rf_wr_data !== 32'd200) begin
            errors++;
            $display("FAIL full_drain: pend=%0d wr_rdy=%0b rd_rdy=%0b rw=%0b wa=%0d wd=%0d",
                     pending, bus.wr_ready, bus.rd_ready, rf_rw_en, rf_wr_addr, rf_wr_data);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (pending !== 3'd3 || bus.rd_ready !== 1'b1 || rf_rw_en !== 1'b1) begin
            errors++;
            $display("FAIL full_then_read: pend=%0d rd_rdy=%0b rw=%0b want 3/1/1",
                     pending, bus.rd_ready, rf_rw_en);
        end
        next_cycle();
        idle_inputs();
        wait_drain();
    endtask

    task automatic test_same_cycle();
        drive_wr(5'd9, 32'd1);
        next_cycle();
        idle_inputs();
        wait_drain();
        drive_wr(5'd9, 32'd44);
        drive_rd(5'd9, 5'd9);
        @(negedge clk);
        checks++;
        if (bus.rd_ready !== 1'b1 || rf_rw_en !== 1'b1) begin
            errors++;
            $display("FAIL same_accept: rd_rdy=%0b rw=%0b want 1/1", bus.rd_ready, rf_rw_en);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.rsp_data1 !== 32'd1 || bus.rsp_data2 !== 32'd1 || rf_rw_en !== 1'b0) begin
            errors++;
            $display("FAIL same_not_forwarded: d1=%0d d2=%0d rw=%0b want 1/1/0",
                     bus.rsp_data1, bus.rsp_data2, rf_rw_en);
        end
        next_cycle();
        drive_rd(5'd9, 5'd9);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data1 !== 32'd44 || bus.rsp_data2 !== 32'd44) begin
            errors++;
            $display("FAIL read_after_drain: v=%0b d1=%0d d2=%0d want 1/44/44",
                     bus.rsp_valid, bus.rsp_data1, bus.rsp_data2);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data1 !== 32'd44) begin
            errors++;
            $display("FAIL rsp_hold: v=%0b d1=%0d want 0/44", bus.rsp_valid, bus.rsp_data1);
        end
        next_cycle();
    endtask

    task automatic test_zero_reg();
        logic [2:0]    exp_pend;
        logic [DW-1:0] exp_d;
`ifdef RF_ACCESS_ZERO_REG_EN
        exp_pend = 3'd0;
        exp_d    = '0;
`else
        exp_pend = 3'd1;
        exp_d    = 32'd77;
`endif
        drive_wr(5'd0, 32'd77);
        next_cycle();
        idle_inputs();
        drive_rd(5'd0, 5'd0);
        @(negedge clk);
        checks++;
        if (pending !== exp_pend) begin
            errors++;
            $display("FAIL zero_push: pend=%0d want %0d", pending, exp_pend);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.rsp_data1 !== exp_d || bus.rsp_data2 !== exp_d) begin
            errors++;
            $display("FAIL zero_read: d1=%0d d2=%0d want %0d",
                     bus.rsp_data1, bus.rsp_data2, exp_d);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        drive_rd(5'd1, 5'd2);
        for (int i = 0; i < 3; i++) begin
            drive_wr(5'(20 + i), 32'(300 + i));
            next_cycle();
        end
        bus.wr_valid = 1'b0;
        next_cycle();
        checks++;
        if (bus.rsp_valid !== 1'b1 || pending !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset: v=%0b pend=%0d want 1/3", bus.rsp_valid, pending);
        end
        #1;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (pending !== 3'd0 || bus.rsp_valid !== 1'b0 || bus.rsp_data1 !== '0 ||
            rf_rw_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: pend=%0d v=%0b d1=%h rw=%0b want 0/0/0/1",
                     pending, bus.rsp_valid, bus.rsp_data1, rf_rw_en);
        end
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rf_rw_en !== 1'b1 || pending !== 3'd0) begin
                errors++;
                $display("FAIL after_reset_cycle%0d: rw=%0b pend=%0d want 1/0",
                         i, rf_rw_en, pending);
            end
        end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_drain();
        test_read();
        test_forward();
        test_full();
        test_same_cycle();
        test_zero_reg();
        test_reset_mid();
        checks++;
        if (scb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries want 0", scb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
